// File: rtl/bicubic_interp_pipe.sv
// rtl/bicubic_interp_pipe.sv - 4-stage Catmull-Rom / bilinear / nearest 1-D interpolator.
// Optional OUT_SAT and SAT_CNT ports are enabled by BICUBIC_SAT_CNT_EN.

module bicubic_interp_pipe #(
   parameter int DW   = 8,
   parameter int FW   = 8,
   parameter int TAGW = 14
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [4*DW-1:0]   IN_P,
   input  logic [FW-1:0]     IN_T,
   input  logic [1:0]        IN_MODE,
   input  logic [TAGW-1:0]   IN_TAG,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [DW-1:0]     OUT_PIX,
`ifdef BICUBIC_SAT_CNT_EN
   output logic              OUT_SAT,
   output logic [15:0]       SAT_CNT,
`endif
   output logic [TAGW-1:0]   OUT_TAG
);

   localparam int CW = DW + 4;
   localparam int HW = DW + 3*FW + 6;
   localparam logic signed [HW-1:0] ROUND = {{(HW-1){1'b0}}, 1'b1} << (3*FW);
   localparam logic signed [HW-1:0] PMAX  = {{(HW-DW){1'b0}}, {DW{1'b1}}};

   function automatic logic signed [HW-1:0] sx(input logic signed [CW-1:0] v);
      return {{(HW-CW){v[CW-1]}}, v};
   endfunction

   function automatic logic signed [HW-1:0] tx(input logic [FW-1:0] v);
      return {{(HW-FW){1'b0}}, v};
   endfunction

   logic                   adv;
   logic signed [CW-1:0]   p0x, p1x, p2x, p3x;
   logic signed [CW-1:0]   a2_c, b2_c, c2_c, d2_c;
   logic signed [HW-1:0]   h1_c, h2_c, h3_c, r_c;
   logic [DW-1:0]          pix_c;
   logic                   clamp_c;

   logic                   s1_v_q, s1_v_d;
   logic signed [CW-1:0]   a2_q, a2_d, b2_q, b2_d, c2_q, c2_d, d2_q, d2_d;
   logic [FW-1:0]          t1_q, t1_d;
   logic [TAGW-1:0]        tag1_q, tag1_d;

   logic                   s2_v_q, s2_v_d;
   logic signed [HW-1:0]   h1_q, h1_d;
   logic signed [CW-1:0]   c2_s2_q, c2_s2_d, d2_s2_q, d2_s2_d;
   logic [FW-1:0]          t2_q, t2_d;
   logic [TAGW-1:0]        tag2_q, tag2_d;

   logic                   s3_v_q, s3_v_d;
   logic signed [HW-1:0]   h2_q, h2_d;
   logic signed [CW-1:0]   d2_s3_q, d2_s3_d;
   logic [FW-1:0]          t3_q, t3_d;
   logic [TAGW-1:0]        tag3_q, tag3_d;

   logic                   s4_v_q, s4_v_d;
   logic [DW-1:0]          pix_q, pix_d;
   logic [TAGW-1:0]        tag4_q, tag4_d;
`ifdef BICUBIC_SAT_CNT_EN
   logic                   sat_q, sat_d;
   logic [15:0]            sat_cnt_q, sat_cnt_d;
`endif

   always_comb begin
      adv = !s4_v_q || OUT_READY;

      p0x = $signed({4'b0000, IN_P[DW-1:0]});
      p1x = $signed({4'b0000, IN_P[2*DW-1:DW]});
      p2x = $signed({4'b0000, IN_P[3*DW-1:2*DW]});
      p3x = $signed({4'b0000, IN_P[4*DW-1:3*DW]});

      // Bilinear and nearest reuse the cubic datapath with degenerate coefficients,
      // so the common rounding step yields their exact formulas.
      a2_c = '0;
      b2_c = '0;
      c2_c = '0;
      d2_c = p1x <<< 1;
      case (IN_MODE)
         2'd1: c2_c = (p2x - p1x) <<< 1;
         2'd2: d2_c = IN_T[FW-1] ? (p2x <<< 1) : (p1x <<< 1);
         default: begin
            a2_c = p3x - p0x + ((p1x <<< 1) + p1x) - ((p2x <<< 1) + p2x);
            b2_c = (p0x <<< 1) - ((p1x <<< 2) + p1x) + (p2x <<< 2) - p3x;
            c2_c = p2x - p0x;
         end
      endcase

      h1_c = sx(a2_q) * tx(t1_q) + (sx(b2_q) <<< FW);
      h2_c = h1_q * tx(t2_q) + (sx(c2_s2_q) <<< (2*FW));
      h3_c = h2_q * tx(t3_q) + (sx(d2_s3_q) <<< (3*FW));
      r_c  = (h3_c + ROUND) >>> (3*FW + 1);

      clamp_c = 1'b1;
      if (r_c[HW-1]) begin
         pix_c = '0;
      end else if (r_c > PMAX) begin
         pix_c = '1;
      end else begin
         pix_c   = r_c[DW-1:0];
         clamp_c = 1'b0;
      end

      s1_v_d  = s1_v_q;  a2_d = a2_q; b2_d = b2_q; c2_d = c2_q; d2_d = d2_q;
      t1_d    = t1_q;    tag1_d = tag1_q;
      s2_v_d  = s2_v_q;  h1_d = h1_q; c2_s2_d = c2_s2_q; d2_s2_d = d2_s2_q;
      t2_d    = t2_q;    tag2_d = tag2_q;
      s3_v_d  = s3_v_q;  h2_d = h2_q; d2_s3_d = d2_s3_q; t3_d = t3_q; tag3_d = tag3_q;
      s4_v_d  = s4_v_q;  pix_d = pix_q; tag4_d = tag4_q;
`ifdef BICUBIC_SAT_CNT_EN
      sat_d     = sat_q;
      sat_cnt_d = sat_cnt_q;
      if (s4_v_q && OUT_READY && sat_q && (sat_cnt_q != 16'hFFFF))
         sat_cnt_d = sat_cnt_q + 16'd1;
`endif

      if (adv) begin
         s1_v_d  = IN_VALID;
         a2_d    = a2_c;  b2_d = b2_c;  c2_d = c2_c;  d2_d = d2_c;
         t1_d    = IN_T;  tag1_d = IN_TAG;
         s2_v_d  = s1_v_q;
         h1_d    = h1_c;  c2_s2_d = c2_q;  d2_s2_d = d2_q;
         t2_d    = t1_q;  tag2_d = tag1_q;
         s3_v_d  = s2_v_q;
         h2_d    = h2_c;  d2_s3_d = d2_s2_q;
         t3_d    = t2_q;  tag3_d = tag2_q;
         s4_v_d  = s3_v_q;
         // Output registers only take a new value from a real beat, never a bubble.
         if (s3_v_q) begin
            pix_d  = pix_c;
            tag4_d = tag3_q;
`ifdef BICUBIC_SAT_CNT_EN
            sat_d  = clamp_c;
`endif
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1_v_q  <= 1'b0; a2_q <= '0; b2_q <= '0; c2_q <= '0; d2_q <= '0;
         t1_q    <= '0;   tag1_q <= '0;
         s2_v_q  <= 1'b0; h1_q <= '0; c2_s2_q <= '0; d2_s2_q <= '0;
         t2_q    <= '0;   tag2_q <= '0;
         s3_v_q  <= 1'b0; h2_q <= '0; d2_s3_q <= '0; t3_q <= '0; tag3_q <= '0;
         s4_v_q  <= 1'b0; pix_q <= '0; tag4_q <= '0;
`ifdef BICUBIC_SAT_CNT_EN
         sat_q     <= 1'b0;
         sat_cnt_q <= '0;
`endif
      end else begin
         s1_v_q  <= s1_v_d; a2_q <= a2_d; b2_q <= b2_d; c2_q <= c2_d; d2_q <= d2_d;
         t1_q    <= t1_d;   tag1_q <= tag1_d;
         s2_v_q  <= s2_v_d; h1_q <= h1_d; c2_s2_q <= c2_s2_d; d2_s2_q <= d2_s2_d;
         t2_q    <= t2_d;   tag2_q <= tag2_d;
         s3_v_q  <= s3_v_d; h2_q <= h2_d; d2_s3_q <= d2_s3_d; t3_q <= t3_d; tag3_q <= tag3_d;
         s4_v_q  <= s4_v_d; pix_q <= pix_d; tag4_q <= tag4_d;
`ifdef BICUBIC_SAT_CNT_EN
         sat_q     <= sat_d;
         sat_cnt_q <= sat_cnt_d;
`endif
      end
   end

   assign IN_READY  = adv;
   assign OUT_VALID = s4_v_q;
   assign OUT_PIX   = pix_q;
   assign OUT_TAG   = tag4_q;
`ifdef BICUBIC_SAT_CNT_EN
   assign OUT_SAT   = s4_v_q && sat_q;
   assign SAT_CNT   = sat_cnt_q;
`endif

endmodule

// File: tb/tb_bicubic_interp_pipe.sv
// tb/tb_bicubic_interp_pipe.sv - self-checking bench for bicubic_interp_pipe (DW=8, FW=8).
// Vector table plus scoreboard; SAT checks compiled in with BICUBIC_SAT_CNT_EN.

module tb_bicubic_interp_pipe;
   localparam int DW = 8, FW = 8, TAGW = 14;

   logic              CLK = 1'b0;
   logic              RST;
   logic              IN_VALID;
   logic              IN_READY;
   logic [4*DW-1:0]   IN_P;
   logic [FW-1:0]     IN_T;
   logic [1:0]        IN_MODE;
   logic [TAGW-1:0]   IN_TAG;
   logic              OUT_VALID;
   logic              OUT_READY;
   logic [DW-1:0]     OUT_PIX;
   logic [TAGW-1:0]   OUT_TAG;
`ifdef BICUBIC_SAT_CNT_EN
   logic              OUT_SAT;
   logic [15:0]       SAT_CNT;
`endif

   bicubic_interp_pipe #(.DW(DW), .FW(FW), .TAGW(TAGW)) dut (
      .CLK(CLK), .RST(RST),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_P(IN_P), .IN_T(IN_T),
      .IN_MODE(IN_MODE), .IN_TAG(IN_TAG),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_PIX(OUT_PIX),
`ifdef BICUBIC_SAT_CNT_EN
      .OUT_SAT(OUT_SAT), .SAT_CNT(SAT_CNT),
`endif
      .OUT_TAG(OUT_TAG)
   );

   always #5 CLK = ~CLK;

   typedef struct { int p0, p1, p2, p3, t, mode, tag, pix, sat; } vec_t;
   typedef struct { int pix, tag, sat, cyc; } exp_t;

   vec_t  tbl[8];
   exp_t  sb[$];
   exp_t  cur_exp;
   int    n_chk = 0, n_pass = 0, cyc = 0;
   bit    lat_chk = 0, in_fired = 0;

   function automatic void chk(string name, longint act, longint req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endfunction

   // Expanded-polynomial form of the Catmull-Rom kernel, direct bilinear and nearest.
   function automatic int model(int p0, int p1, int p2, int p3, int t, int mode, output int sat);
      longint a, b, c, d, h, r;
      sat = 0;
      if (mode == 1) return ((p1 <<< 8) + (p2 - p1) * t + 128) >>> 8;
      if (mode == 2) return (t < 128) ? p1 : p2;
      a = -p0 + 3*p1 - 3*p2 + p3;
      b = 2*p0 - 5*p1 + 4*p2 - p3;
      c = p2 - p0;
      d = 2*p1;
      h = a*t*t*t + b*t*t*256 + c*t*65536 + d*64'sd16777216;
      r = (h + 64'sd16777216) >>> 25;
      if (r < 0)   begin sat = 1; return 0;   end
      if (r > 255) begin sat = 1; return 255; end
      return int'(r);
   endfunction

   task automatic drive(input int p0, p1, p2, p3, t, mode, tag, pix, sat);
      IN_P    = {DW'(p3), DW'(p2), DW'(p1), DW'(p0)};
      IN_T    = FW'(t);
      IN_MODE = 2'(mode);
      IN_TAG  = TAGW'(tag);
      cur_exp.pix = pix; cur_exp.tag = tag; cur_exp.sat = sat; cur_exp.cyc = 0;
   endtask

   task automatic new_beat(input int tag);
      int p0, p1, p2, p3, t, mode, sat, pix;
      p0 = $urandom_range(0, 255); p1 = $urandom_range(0, 255);
      p2 = $urandom_range(0, 255); p3 = $urandom_range(0, 255);
      case ($urandom_range(0, 7))
         0: t = 0;
         1: t = 127;
         2: t = 128;
         3: t = 255;
         default: t = $urandom_range(0, 255);
      endcase
      mode = $urandom_range(0, 3);
      pix  = model(p0, p1, p2, p3, t, mode, sat);
      drive(p0, p1, p2, p3, t, mode, tag, pix, sat);
   endtask

   // Called at a negedge after inputs are set; returns at the next negedge.
   task automatic tick();
      exp_t e;
      #1;
      in_fired = 0;
      if (OUT_VALID && OUT_READY) begin
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_output: got pix %0d tag %0d, expected no output", OUT_PIX, OUT_TAG);
         end else begin
            e = sb.pop_front();
            chk("pix", OUT_PIX, e.pix);
            chk("tag", OUT_TAG, e.tag);
`ifdef BICUBIC_SAT_CNT_EN
            chk("out_sat", OUT_SAT, e.sat);
`endif
            if (lat_chk) chk("latency", cyc - e.cyc, 4);
         end
      end
      if (IN_VALID && IN_READY) begin
         e = cur_exp;
         e.cyc = cyc;
         sb.push_back(e);
         in_fired = 1;
      end
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
   endtask

   task automatic drain();
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      for (int i = 0; i < 200 && sb.size() > 0; i++) tick();
      chk("drain_left", sb.size(), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, sent, snap_pix, snap_tag;
      tbl[0] = '{0,   0,   255, 255, 128, 0, 1,  128, 0};
      tbl[1] = '{0,   255, 255, 0,   128, 0, 2,  255, 1};
      tbl[2] = '{255, 0,   0,   255, 128, 0, 3,  0,   1};
      tbl[3] = '{0,   10,  20,  0,   128, 1, 4,  15,  0};
      tbl[4] = '{0,   10,  20,  0,   127, 2, 5,  10,  0};
      tbl[5] = '{0,   10,  20,  0,   128, 2, 6,  20,  0};
      tbl[6] = '{0,   10,  20,  0,   0,   0, 7,  10,  0};
      tbl[7] = '{0,   200, 100, 0,   64,  1, 8,  175, 0};

      RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
      IN_P = '0; IN_T = '0; IN_MODE = '0; IN_TAG = '0;
      repeat (2) @(negedge CLK);
      chk("rst_out_valid", OUT_VALID, 0);
      chk("rst_out_pix", OUT_PIX, 0);
      chk("rst_out_tag", OUT_TAG, 0);
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_in_ready", IN_READY, 1);
`ifdef BICUBIC_SAT_CNT_EN
      chk("rst_sat_cnt", SAT_CNT, 0);
`endif

      // Directed vectors back-to-back, with fixed-latency checking.
      lat_chk = 1;
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].p0, tbl[i].p1, tbl[i].p2, tbl[i].p3, tbl[i].t, tbl[i].mode,
               tbl[i].tag, tbl[i].pix, tbl[i].sat);
         IN_VALID = 1'b1;
         tick();
      end
      drain();
`ifdef BICUBIC_SAT_CNT_EN
      chk("sat_cnt_after_table", SAT_CNT, 2);
`endif
      lat_chk = 0;

      // Backpressure: 8 beats, OUT_READY low for 3 cycles mid-stream.
      k = 0; snap_pix = 0; snap_tag = 0;
      new_beat(200);
      for (int i = 0; i < 40 && (k < 8 || sb.size() > 0); i++) begin
         OUT_READY = !(i >= 6 && i < 9);
         IN_VALID  = (k < 8);
         #1;
         if (i >= 6 && i < 9) begin
            chk("bp_out_valid", OUT_VALID, 1);
            chk("bp_in_ready", IN_READY, 0);
            if (i == 6) begin
               snap_pix = OUT_PIX;
               snap_tag = OUT_TAG;
            end else begin
               chk("bp_pix_stable", OUT_PIX, snap_pix);
               chk("bp_tag_stable", OUT_TAG, snap_tag);
            end
         end
         tick();
         if (in_fired) begin
            k++;
            new_beat(200 + k);
         end
      end
      chk("bp_beats_sent", k, 8);
      drain();

      // Reset with three beats in flight, one already presented at the output.
      OUT_READY = 1'b1;
      for (int j = 0; j < 3; j++) begin
         new_beat(300 + j);
         IN_VALID = 1'b1;
         tick();
      end
      IN_VALID  = 1'b0;
      OUT_READY = 1'b0;
      tick();
      chk("pre_rst_out_valid", OUT_VALID, 1);
      RST = 1'b1;
      #1;
      chk("rst_async_out_valid", OUT_VALID, 0);
      sb.delete();
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      OUT_READY = 1'b1;
      for (int j = 0; j < 8; j++) begin
         #1;
         chk("post_rst_idle", OUT_VALID, 0);
         tick();
      end
      lat_chk = 1;
      new_beat(400);
      IN_VALID = 1'b1;
      tick();
      drain();
      lat_chk = 0;

      // Random sweep with random valid and ready.
      sent = 0;
      new_beat(0);
      for (int c = 0; c < 60000 && sent < 10000; c++) begin
         IN_VALID  = ($urandom_range(0, 3) != 0);
         OUT_READY = ($urandom_range(0, 3) != 0);
         tick();
         if (in_fired) begin
            sent++;
            new_beat(sent & 16'h3FFF);
         end
      end
      chk("rand_beats_sent", sent, 10000);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
